// File: rtl/seq_scan_pkg.sv
// Shared types and sizing helpers for the sequence pattern scanner.
package seq_scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int DEF_SEQ_W = 10;
   localparam int DEF_PAT_W = 3;
   localparam int DEF_CNT_W = 4;

   function automatic int pos_width(input int seq_w);
      return (seq_w < 2) ? 1 : $clog2(seq_w);
   endfunction

endpackage

// File: rtl/pattern_window.sv
// Sliding PAT_W-bit window over the consumed bit stream; match is combinational on the post-shift window.
// Match only fires once PAT_W bits have been seen since the last clear, so stale zeros never match.
module pattern_window #(
   parameter int PAT_W = 3
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_clear,
   input  logic             i_shift,
   input  logic             i_bit,
   input  logic [PAT_W-1:0] i_pattern,
   output logic             o_match
);
   localparam int SEEN_W = $clog2(PAT_W + 1);

   logic [PAT_W-1:0]  r_window;
   logic [PAT_W-1:0]  w_window_nxt;
   logic [SEEN_W-1:0] r_seen;
   logic [SEEN_W-1:0] w_seen_nxt;

   // Truncating cast keeps the low PAT_W bits, which also covers PAT_W == 1.
   assign w_window_nxt = PAT_W'({r_window, i_bit});
   assign w_seen_nxt   = (r_seen == SEEN_W'(PAT_W)) ? r_seen : r_seen + SEEN_W'(1);
   assign o_match      = i_shift && (w_window_nxt == i_pattern) && (w_seen_nxt == SEEN_W'(PAT_W));

   always_ff @(posedge i_clock) begin
      if (i_reset || i_clear) begin
         r_window <= '0;
         r_seen   <= '0;
      end else if (i_shift) begin
         r_window <= w_window_nxt;
         r_seen   <= w_seen_nxt;
      end
   end

endmodule

// File: rtl/seq_pattern_scanner.sv
// Shifts a loaded sequence out MSB-first one bit per clock and counts pattern matches (saturating), with pause and loop mode.
// SEQ_SCAN_DEBUG_EN adds o_state_dbg and o_debug_sequence_reg; behaviour is otherwise identical.
module seq_pattern_scanner
   import seq_scan_pkg::*;
#(
   parameter int  SEQ_W = DEF_SEQ_W,
   parameter int  PAT_W = DEF_PAT_W,
   parameter int  CNT_W = DEF_CNT_W,
   localparam int POS_W = pos_width(SEQ_W)
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic [SEQ_W-1:0] i_sequence,
   input  logic [PAT_W-1:0] i_pattern,
   input  logic             i_load,
   input  logic             i_pause,
   input  logic             i_loop_mode,
   output logic [CNT_W-1:0] o_count,
   output logic             o_bit_out,
   output logic [POS_W-1:0] o_pos,
   output logic             o_done
`ifdef SEQ_SCAN_DEBUG_EN
   ,
   output logic [1:0]       o_state_dbg,
   output logic [SEQ_W-1:0] o_debug_sequence_reg
`endif
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [SEQ_W-1:0] r_shift;
   logic [SEQ_W-1:0] r_seq_copy;
   logic [PAT_W-1:0] r_pattern;
   logic             r_mode;
   logic [CNT_W-1:0] r_count;
   logic             r_bit_out;
   logic [POS_W-1:0] r_pos;
   logic             w_consume;
   logic             w_last;
   logic             w_match;

   assign w_consume = (r_state == ST_RUN) && !i_pause && !i_load;
   assign w_last    = (r_pos == POS_W'(SEQ_W - 1));

   pattern_window #(.PAT_W(PAT_W)) u_window (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_clear   (i_load),
      .i_shift   (w_consume),
      .i_bit     (r_shift[SEQ_W-1]),
      .i_pattern (r_pattern),
      .o_match   (w_match)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (i_load) begin
         w_state_nxt = ST_RUN;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (i_pause)              w_state_nxt = ST_PAUSED;
               else if (w_last && !r_mode) w_state_nxt = ST_DONE;
            end
            ST_PAUSED: if (!i_pause) w_state_nxt = ST_RUN;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_shift    <= '0;
         r_seq_copy <= '0;
         r_pattern  <= '0;
         r_mode     <= 1'b0;
         r_count    <= '0;
         r_bit_out  <= 1'b0;
         r_pos      <= '0;
      end else if (i_load) begin
         r_shift    <= i_sequence;
         r_seq_copy <= i_sequence;
         r_pattern  <= i_pattern;
         r_mode     <= i_loop_mode;
         r_count    <= '0;
         r_pos      <= '0;
      end else if (w_consume) begin
         r_bit_out <= r_shift[SEQ_W-1];
         // In loop mode the lap boundary reloads the sequence; the window keeps its history across the wrap.
         if (w_last && r_mode) r_shift <= r_seq_copy;
         else                  r_shift <= {r_shift[SEQ_W-2:0], 1'b0};
         r_pos <= w_last ? '0 : r_pos + POS_W'(1);
         if (w_match && (r_count != CNT_MAX)) r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_count   = r_count;
   assign o_bit_out = r_bit_out;
   assign o_pos     = r_pos;
   assign o_done    = (r_state == ST_DONE);

`ifdef SEQ_SCAN_DEBUG_EN
   assign o_state_dbg          = r_state;
   assign o_debug_sequence_reg = r_shift;
`endif

endmodule

// File: tb/tb_seq_pattern_scanner.sv
// Directed bench for seq_pattern_scanner: a bit-indexed reference model feeds a scoreboard checked after every edge.
module tb_seq_pattern_scanner;
   localparam int SEQ_W = 10;
   localparam int PAT_W = 3;
   localparam int CNT_W = 4;
   localparam int POS_W = $clog2(SEQ_W);
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             load = 1'b0;
   logic             pause = 1'b0;
   logic             loop_mode = 1'b0;
   logic [SEQ_W-1:0] seq_in = '0;
   logic [PAT_W-1:0] pat_in = '0;
   logic [CNT_W-1:0] count;
   logic             bit_out;
   logic [POS_W-1:0] pos;
   logic             done;
`ifdef SEQ_SCAN_DEBUG_EN
   logic [1:0]       state_dbg;
   logic [SEQ_W-1:0] dbg_seq;
`endif

   always #5 clk = ~clk;

   seq_pattern_scanner #(.SEQ_W(SEQ_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
      .i_clock     (clk),
      .i_reset     (reset),
      .i_sequence  (seq_in),
      .i_pattern   (pat_in),
      .i_load      (load),
      .i_pause     (pause),
      .i_loop_mode (loop_mode),
      .o_count     (count),
      .o_bit_out   (bit_out),
      .o_pos       (pos),
      .o_done      (done)
`ifdef SEQ_SCAN_DEBUG_EN
      ,
      .o_state_dbg          (state_dbg),
      .o_debug_sequence_reg (dbg_seq)
`endif
   );

   typedef struct {
      int cnt;
      int bo;
      int pos;
      int done;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model: 0=IDLE 1=RUN 2=PAUSED 3=DONE; bits are read by index, not by shifting.
   int               m_state = 0, m_cnt = 0, m_bit = 0, m_pos = 0, m_seen = 0, m_hist = 0;
   logic [SEQ_W-1:0] m_seq = '0;
   logic [PAT_W-1:0] m_pat = '0;
   bit               m_mode = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit rst, input bit ld, input bit ps);
      int b;
      if (rst) begin
         m_state = 0; m_cnt = 0; m_bit = 0; m_pos = 0; m_seen = 0; m_hist = 0;
      end else if (ld) begin
         m_seq = seq_in; m_pat = pat_in; m_mode = loop_mode;
         m_hist = 0; m_seen = 0; m_cnt = 0; m_pos = 0; m_state = 1;
      end else if (m_state == 1) begin
         if (ps) begin
            m_state = 2;
         end else begin
            b = int'(m_seq[SEQ_W-1-m_pos]);
            m_bit = b;
            m_hist = ((m_hist << 1) | b) & ((1 << PAT_W) - 1);
            if (m_seen < PAT_W) m_seen++;
            if (m_seen == PAT_W && m_hist == int'(m_pat) && m_cnt < CMAX) m_cnt++;
            if (m_pos == SEQ_W - 1) begin
               m_pos = 0;
               if (!m_mode) m_state = 3;
            end else begin
               m_pos++;
            end
         end
      end else if (m_state == 2 && !ps) begin
         m_state = 1;
      end
   endtask

   task automatic cyc(input string tag, input bit rst, input bit ld, input bit ps);
      exp_t e;
      reset = rst; load = ld; pause = ps;
      model_edge(rst, ld, ps);
      e.cnt = m_cnt; e.bo = m_bit; e.pos = m_pos; e.done = (m_state == 3) ? 1 : 0;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      chk({tag, "_count"}, 32'(count), e.cnt);
      chk({tag, "_bit"}, 32'(bit_out), e.bo);
      chk({tag, "_pos"}, 32'(pos), e.pos);
      chk({tag, "_done"}, 32'(done), e.done);
   endtask

   task automatic run(input string tag, input int n);
      for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset state
      cyc("rst", 1'b1, 1'b0, 1'b0);
      cyc("rst", 1'b1, 1'b0, 1'b0);
      chk("rst_count", 32'(count), 0);
      chk("rst_done", 32'(done), 0);
      cyc("idle", 1'b0, 1'b0, 1'b1);
      chk("idle_pos", 32'(pos), 0);

      // One-shot 1010101010 / 101: done exactly 10 edges after load
      seq_in = 10'b1010101010; pat_in = 3'b101; loop_mode = 1'b0;
      cyc("t1_ld", 1'b0, 1'b1, 1'b0);
      run("t1", 9);
      chk("t1_done_early", 32'(done), 0);
      run("t1", 1);
      chk("t1_done", 32'(done), 1);
      chk("t1_count", 32'(count), 4);
      chk("t1_pos", 32'(pos), 0);
      chk("t1_bit", 32'(bit_out), 0);
      run("t1_hold", 3);
      chk("t1_hold_count", 32'(count), 4);

      // One-shot 1100101101 / 101: matches on the 7th and 10th consume
      seq_in = 10'b1100101101;
      cyc("t2_ld", 1'b0, 1'b1, 1'b0);
      run("t2", 6);
      chk("t2_c6", 32'(count), 0);
      run("t2", 1);
      chk("t2_c7", 32'(count), 1);
      run("t2", 2);
      chk("t2_c9", 32'(count), 1);
      run("t2", 1);
      chk("t2_c10", 32'(count), 2);
      chk("t2_done", 32'(done), 1);

      // Loop mode: wrap-spanning matches and saturation
      seq_in = 10'b1010101010; loop_mode = 1'b1;
      cyc("t3_ld", 1'b0, 1'b1, 1'b0);
      run("t3", 10);
      chk("t3_lap1", 32'(count), 4);
      run("t3", 10);
      chk("t3_lap2", 32'(count), 9);
      run("t3", 10);
      chk("t3_lap3", 32'(count), 14);
      run("t3", 10);
      chk("t3_lap4", 32'(count), 15);
      chk("t3_nodone", 32'(done), 0);
      run("t3", 3);
      chk("t3_sat", 32'(count), 15);

      // Pause held 5 cycles mid-run: done 6 edges later than normal
      loop_mode = 1'b0;
      cyc("t4_ld", 1'b0, 1'b1, 1'b0);
      run("t4", 4);
      chk("t4_pos4", 32'(pos), 4);
      chk("t4_cnt4", 32'(count), 1);
      for (int i = 0; i < 5; i++) cyc("t4_p", 1'b0, 1'b0, 1'b1);
      chk("t4_pfrz_pos", 32'(pos), 4);
      chk("t4_pfrz_cnt", 32'(count), 1);
      cyc("t4_bub", 1'b0, 1'b0, 1'b0);
      chk("t4_bub_pos", 32'(pos), 4);
      run("t4", 5);
      chk("t4_done_early", 32'(done), 0);
      run("t4", 1);
      chk("t4_done", 32'(done), 1);
      chk("t4_count", 32'(count), 4);

      // load with pause on the same edge: load wins and starts consuming next edge
      cyc("t5_ld", 1'b0, 1'b1, 1'b0);
      run("t5", 5);
      chk("t5_mid_cnt", 32'(count), 2);
      cyc("t5_ldp", 1'b0, 1'b1, 1'b1);
      chk("t5_ldp_cnt", 32'(count), 0);
      chk("t5_ldp_pos", 32'(pos), 0);
      run("t5", 1);
      chk("t5_run_pos", 32'(pos), 1);
      run("t5", 3);
      cyc("t5_rstld", 1'b1, 1'b1, 1'b0);
      chk("t5_rstld_cnt", 32'(count), 0);
      chk("t5_rstld_pos", 32'(pos), 0);
      run("t5_idle", 2);
      chk("t5_idle_pos", 32'(pos), 0);

      // Reset mid-loop after count reaches 7, then a fresh one-shot run
      loop_mode = 1'b1;
      cyc("t6_ld", 1'b0, 1'b1, 1'b0);
      run("t6", 15);
      chk("t6_cnt7", 32'(count), 7);
      cyc("t6_rst", 1'b1, 1'b0, 1'b0);
      chk("t6_rst_cnt", 32'(count), 0);
      chk("t6_rst_done", 32'(done), 0);
      chk("t6_rst_pos", 32'(pos), 0);
      run("t6_idle", 2);
      loop_mode = 1'b0;
      cyc("t6_ld2", 1'b0, 1'b1, 1'b0);
      run("t6b", 10);
      chk("t6_fresh_cnt", 32'(count), 4);
      chk("t6_fresh_done", 32'(done), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
